// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Iterative shift-and-add multiplier for the ALU multiply operation.
//   A start pulse in IDLE captures the operands. RUN performs one add/shift
//   step per clock for WIDTH clocks. DONE presents the 2*WIDTH-bit product
//   with a one-cycle done pulse.
//
//   Build option: define MULT_SIGNED_EN for a two's-complement multiply.
//   Without it, the operands and the product are unsigned.
//
// Ports
//   clk      in   1        rising-edge clock
//   rst_n    in   1        asynchronous active-low reset
//   start    in   1        multiply request, sampled only in IDLE
//   op_a     in   WIDTH    multiplicand, captured on the accepting edge
//   op_b     in   WIDTH    multiplier, captured on the accepting edge
//   product  out  2*WIDTH  result, held until the next multiply completes
//   busy     out  1        high in RUN and DONE
//   done     out  1        one-cycle pulse while product is fresh
//   ovf      out  1        product does not fit a WIDTH-bit result
//
// States
//   state  | meaning
//   IDLE   | waiting for start; product/ovf hold the last result
//   RUN    | one add/shift step per clock, WIDTH steps in total
//   DONE   | product valid, done pulse, returns to IDLE

module shift_add_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ovf_q, ovf_d;

    logic                 last_step;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   shifted;

    assign last_step = (cnt_q == CW'(WIDTH - 1));

    // One step of the datapath. The sum is WIDTH+1 bits wide. Its top bit
    // becomes the bit that is shifted into acc_hi.
    always_comb begin
        sum = '0;
`ifdef MULT_SIGNED_EN
        // Two's complement: sign-extend both terms. The last multiplier bit
        // carries negative weight, so that step subtracts the multiplicand.
        if (acc_lo_q[0]) begin
            if (last_step) begin
                sum = {acc_hi_q[WIDTH-1], acc_hi_q} - {mcand_q[WIDTH-1], mcand_q};
            end else begin
                sum = {acc_hi_q[WIDTH-1], acc_hi_q} + {mcand_q[WIDTH-1], mcand_q};
            end
        end else begin
            sum = {acc_hi_q[WIDTH-1], acc_hi_q};
        end
`else
        if (acc_lo_q[0]) begin
            sum = {1'b0, acc_hi_q} + {1'b0, mcand_q};
        end else begin
            sum = {1'b0, acc_hi_q};
        end
`endif
        shifted = {sum, acc_lo_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        ovf_d     = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    acc_hi_d = '0;
                    acc_lo_d = op_b;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_hi_d = shifted[2*WIDTH-1:WIDTH];
                acc_lo_d = shifted[WIDTH-1:0];
                cnt_d    = cnt_q + CW'(1);
                if (last_step) begin
                    state_d   = S_DONE;
                    product_d = shifted;
`ifdef MULT_SIGNED_EN
                    // The result fits only if the upper half and the sign bit of the lower half all match.
                    ovf_d = ~((&shifted[2*WIDTH-1:WIDTH-1]) | ~(|shifted[2*WIDTH-1:WIDTH-1]));
`else
                    ovf_d = |shifted[2*WIDTH-1:WIDTH];
`endif
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    assign product = product_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign ovf     = ovf_q;

endmodule
